// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP-adder feeder.
//   FEEDER_DEPTH   : default entry count of the pair and result FIFOs
//   pair_t         : one operand pair {a, b}, IEEE-754 single each
//   feeder_state_t : issue sequencer states
package fpadd_pkg;

  localparam int unsigned FEEDER_DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    ARM,
    SEND_A,
    SEND_B
  } feeder_state_t;

endpackage

// File: rtl/fpadd_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, head visible combinationally.
//   clock, nreset      : rising-edge clock, async active-low reset
//   push, push_data    : write request / data
//   pop                : read request (ignored when empty)
//   head               : entry at read pointer
//   count, full, empty : occupancy and flags
module fpadd_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a push is accepted even when full.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpadd_feeder.sv
// Feeds buffered operand pairs to a serial FP adder over a single operand
// bus and collects the sums in order.
//   clock, nreset        : rising-edge clock, async active-low reset
//   in_valid/in_ready    : operand-pair handshake, in_a/in_b operands
//   add_ready            : adder loop marker (high 2 cycles per loop)
//   add_opnd             : serial operand bus (A then B), 0 when idle
//   add_sum              : adder sum from the previous loop
//   res_valid/res_ready  : result handshake, res_data = result FIFO head
//   busy                 : pairs buffered, sequence in flight or sum pending
module fpadd_feeder
  import fpadd_pkg::*;
#(
  parameter int unsigned DEPTH = FEEDER_DEPTH
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        add_ready,
  output logic [31:0] add_opnd,
  input  logic [31:0] add_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  feeder_state_t state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          outstanding_q, outstanding_d;
  logic [31:0]   add_opnd_q, add_opnd_d;
  logic [31:0]   b_q, b_d;
  logic          busy_q, busy_d;

  pair_t         pair_in, pair_head;
  logic [CW-1:0] pair_count, res_count, res_after, pair_cnt_next;
  logic          pair_full, pair_empty, res_full, res_empty;
  logic          pair_push, issue, res_pop;
  logic          rise, capture, credit_ok;

  assign pair_in   = '{a: in_a, b: in_b};
  assign pair_push = in_valid & in_ready;
  assign res_pop   = res_valid & res_ready;

  assign rise    = add_ready & ~rdy_q;
  assign capture = rise & outstanding_q;

  // Issue only when the result FIFO still has room for this pair's sum once
  // any sum captured on this same rise is counted.
  assign res_after = res_count + CW'(capture);
  assign credit_ok = ~res_full & (res_after < CW'(DEPTH));

  fpadd_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_pair_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (pair_push),
    .push_data (pair_in),
    .pop       (issue),
    .head      (pair_head),
    .count     (pair_count),
    .full      (pair_full),
    .empty     (pair_empty)
  );

  fpadd_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (capture),
    .push_data (add_sum),
    .pop       (res_pop),
    .head      (res_data),
    .count     (res_count),
    .full      (res_full),
    .empty     (res_empty)
  );

  always_comb begin
    state_d       = state_q;
    rdy_d         = add_ready;
    outstanding_d = outstanding_q;
    add_opnd_d    = '0;
    b_d           = b_q;
    issue         = 1'b0;

    if (capture) begin
      outstanding_d = 1'b0;
    end

    unique case (state_q)
      ARM: begin
        if (rise && !pair_empty && credit_ok) begin
          issue      = 1'b1;
          add_opnd_d = pair_head.a;
          b_d        = pair_head.b;
          state_d    = SEND_A;
        end
      end
      SEND_A: begin
        add_opnd_d = b_q;
        state_d    = SEND_B;
      end
      SEND_B: begin
        outstanding_d = 1'b1;
        state_d       = ARM;
      end
      default: state_d = ARM;
    endcase

    // busy is registered, so it is built from next-cycle values.
    pair_cnt_next = pair_count + CW'(pair_push) - CW'(issue);
    busy_d        = (pair_cnt_next != '0) | (state_d != ARM) | outstanding_d;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ARM;
      rdy_q         <= 1'b0;
      outstanding_q <= 1'b0;
      add_opnd_q    <= '0;
      b_q           <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      outstanding_q <= outstanding_d;
      add_opnd_q    <= add_opnd_d;
      b_q           <= b_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready  = ~pair_full;
  assign res_valid = ~res_empty;
  assign add_opnd  = add_opnd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpadd_feeder.sv
// Bench for fpadd_feeder paired with a behavioural serial FP adder.
module tb_fpadd_feeder;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        add_ready;
  logic [31:0] add_opnd;
  logic [31:0] add_sum;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;

  int          ntests = 0;
  int          nfail = 0;
  int          nres = 0;
  int          win_viol = 0;
  logic [31:0] exp_q[$];
  logic        saw_full = 1'b0;
  logic        rnd_on = 1'b0;

  always #5 clock = ~clock;

  fpadd_feeder #(.DEPTH(4)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_ready (add_ready),
    .add_opnd  (add_opnd),
    .add_sum   (add_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // ---------------- float helpers ----------------
  function automatic real fp2r(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (r == 0.0) return '0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] int2fp(input int x);
    logic        s;
    logic [31:0] mag;
    int          p;
    logic [31:0] sh;
    if (x == 0) return '0;
    s   = (x < 0);
    mag = s ? 32'(-x) : 32'(x);
    p   = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) p = i;
    sh = mag << (23 - p);
    return {s, 8'(127 + p), sh[22:0]};
  endfunction

  // ---------------- serial adder model: 8-cycle loop ----------------
  logic [2:0]  ph;
  logic [31:0] sa, sb;
  assign add_ready = (ph == 3'd0) || (ph == 3'd1);

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ph      <= 3'd5;
      sa      <= '0;
      sb      <= '0;
      add_sum <= '0;
    end else begin
      ph <= ph + 3'd1;
      if (ph == 3'd1) sa <= add_opnd;
      if (ph == 3'd2) sb <= add_opnd;
      if (ph == 3'd3) add_sum <= r2fp(fp2r(sa) + fp2r(sb));
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    ntests++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Result scoreboard and operand-window watch.
  always @(negedge clock) begin
    logic [31:0] e;
    if (nreset) begin
      if (res_valid && res_ready) begin
        nres++;
        if (exp_q.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_result got=%h required=none", res_data);
        end else begin
          e = exp_q.pop_front();
          chk("result", res_data, e);
        end
      end
      if (add_opnd != 32'd0 && !(ph == 3'd1 || ph == 3'd2)) win_viol++;
    end
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 400) begin
      saw_full = 1'b1;
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      ntests++;
      nfail++;
      $display("FAIL push_timeout got=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      exp_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_add_opnd"}, add_opnd, 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic        last;
    int          cnt;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   base;
    int   x, y, gap;
    int   v_op, v_rv, v_busy;
    logic found;

    tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1};
    tbl[1] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 0};
    tbl[2] = '{32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 0};
    tbl[3] = '{32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b0, 0};
    tbl[4] = '{32'hBF800000, 32'h40400000, 32'h40000000, 1'b1, 4};

    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    nreset = 1'b1;
    res_ready = 1'b1;

    // Directed vectors; each group ends with a drain and a result count.
    base = nres;
    for (int i = 0; i < 5; i++) begin
      push_pair(tbl[i].a, tbl[i].b, tbl[i].e);
      if (tbl[i].last) begin
        drain();
        chk("group_count", 32'(nres - base), 32'(tbl[i].cnt));
        chk("group_res_valid", 32'(res_valid), 32'd0);
        base = nres;
      end
    end

    // Back-pressure: results stall at FIFO depth, pairs queue up.
    @(negedge clock);
    res_ready = 1'b0;
    saw_full  = 1'b0;
    base = nres;
    for (int k = 1; k <= 6; k++) push_pair(int2fp(k), int2fp(10), int2fp(k + 10));
    repeat (80) @(negedge clock);
    chk("bp_saw_full", 32'(saw_full), 32'd1);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_held", 32'(res_valid), 32'd1);
    end
    @(negedge clock);
    chk("bp_only_four", 32'(res_valid), 32'd0);
    drain();
    chk("bp_count", 32'(nres - base), 32'd6);

    // Random integer operands with random consumer back-pressure.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clock);
          #1 res_ready = ($urandom_range(0, 1) == 1);
        end
        res_ready = 1'b1;
      end
    join_none
    base = nres;
    for (int i = 0; i < 20; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clock);
      x = int'($urandom_range(0, 1000)) - 500;
      y = int'($urandom_range(0, 1000)) - 500;
      push_pair(int2fp(x), int2fp(y), int2fp(x + y));
    end
    rnd_on = 1'b0;
    drain();
    chk("rand_count", 32'(nres - base), 32'd20);

    // Idle: nothing offered for 50 cycles.
    v_op = 0; v_rv = 0; v_busy = 0;
    repeat (50) begin
      @(negedge clock);
      if (add_opnd != 32'd0) v_op++;
      if (res_valid) v_rv++;
      if (busy) v_busy++;
    end
    chk("idle_add_opnd", 32'(v_op), 32'd0);
    chk("idle_res_valid", 32'(v_rv), 32'd0);
    chk("idle_busy", 32'(v_busy), 32'd0);

    // Reset while B is on the bus; the in-flight pair must vanish.
    push_pair(32'h40A00000, 32'h40E00000, 32'h41400000);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      if (ph == 3'd2 && add_opnd != 32'd0) found = 1'b1;
    end
    chk("reach_send_b", 32'(found), 32'd1);
    nreset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk_reset_state("midreset");
    @(negedge clock);
    nreset = 1'b1;
    base = nres;
    push_pair(32'h40400000, 32'h3F800000, 32'h40800000);
    drain();
    repeat (20) @(negedge clock);
    chk("post_reset_count", 32'(nres - base), 32'd1);
    chk("post_reset_res_valid", 32'(res_valid), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    chk("opnd_window", 32'(win_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
